// File: rtl/regs_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the register-file write port
// and the decode hazard lookup. The arbiter sits on the slave modport.
interface regs_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   chk_addr_1;
  logic [AW-1:0]   chk_addr_2;
  logic            chk_hit_1;
  logic            chk_hit_2;
  logic            idle;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr_1, chk_addr_2,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, chk_hit_1, chk_hit_2, idle
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr_1, chk_addr_2,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, chk_hit_1, chk_hit_2, idle
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port: one-entry buffer
// per source, age/starvation-aware grant, registered write port, RAW hazard lookup.
module regs_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_LIM = 4
) (
  input logic              clk,
  input logic              rst,
  regs_wb_arbiter_if.slave bus
);
  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic            bufa_v, bufb_v;
  logic [AW-1:0]   bufa_addr, bufb_addr;
  logic [XLEN-1:0] bufa_data, bufb_data;
  logic            age_b;
  logic [SW-1:0]   starve_cnt;
  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            grant_a, grant_b;
  logic            a_ready_c, b_ready_c;
  logic            a_load, b_load;

  // Grant looks only at buffered entries; age_b=1 means bufB holds the older write.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (bufa_v && bufb_v) begin
      if (bufa_addr == bufb_addr) begin
        grant_b = age_b;
        grant_a = !age_b;
      end else if (starve_cnt == SW'(STARVE_LIM)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = bufa_v;
      grant_b = bufb_v;
    end
  end

  // Handshake: a write transfers at posedge when valid && ready. Ready depends on
  // buffer state only (empty, or draining this cycle), never on valid. A transfer
  // to x0 is acknowledged but not stored.
  assign a_ready_c = !bufa_v || grant_a;
  assign b_ready_c = !bufb_v || grant_b;
  assign a_load    = bus.a_valid && a_ready_c && (bus.a_addr != '0);
  assign b_load    = bus.b_valid && b_ready_c && (bus.b_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bufa_v    <= 1'b0;
      bufa_addr <= '0;
      bufa_data <= '0;
    end else if (a_load) begin
      bufa_v    <= 1'b1;
      bufa_addr <= bus.a_addr;
      bufa_data <= bus.a_data;
    end else if (grant_a) begin
      bufa_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bufb_v    <= 1'b0;
      bufb_addr <= '0;
      bufb_data <= '0;
    end else if (b_load) begin
      bufb_v    <= 1'b1;
      bufb_addr <= bus.b_addr;
      bufb_data <= bus.b_data;
    end else if (grant_b) begin
      bufb_v    <= 1'b0;
    end
  end

  // Simultaneous loads count B as older, so an A load alongside B (or behind a
  // resident B) marks B older.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_b <= 1'b0;
    end else if (a_load && (b_load || bufb_v)) begin
      age_b <= 1'b1;
    end else if (b_load && bufa_v) begin
      age_b <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (bufb_v && !grant_b) begin
      if (starve_cnt != SW'(STARVE_LIM)) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant_a || grant_b;
      if (grant_b) begin
        rf_waddr_q <= bufb_addr;
        rf_wdata_q <= bufb_data;
      end else if (grant_a) begin
        rf_waddr_q <= bufa_addr;
        rf_wdata_q <= bufa_data;
      end
    end
  end

  assign bus.a_ready  = a_ready_c;
  assign bus.b_ready  = b_ready_c;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.idle     = !bufa_v && !bufb_v && !rf_we_q;

  // A register is still in flight while buffered or on the write port this cycle.
  assign bus.chk_hit_1 = (bus.chk_addr_1 != '0) &&
                         ((bufa_v && (bufa_addr == bus.chk_addr_1)) ||
                          (bufb_v && (bufb_addr == bus.chk_addr_1)) ||
                          (rf_we_q && (rf_waddr_q == bus.chk_addr_1)));
  assign bus.chk_hit_2 = (bus.chk_addr_2 != '0) &&
                         ((bufa_v && (bufa_addr == bus.chk_addr_2)) ||
                          (bufb_v && (bufb_addr == bus.chk_addr_2)) ||
                          (rf_we_q && (rf_waddr_q == bus.chk_addr_2)));
endmodule
